// File: rtl/link_writer.sv
// Link-register write buffer: queues jal-style return addresses, shares the single
// RegFile write port with pipeline writeback, and forwards uncommitted links to Read1.
module link_writer #(
   parameter int          DEPTH = 2,
   parameter logic [15:0] INC   = 16'd1
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic                     LinkReq,
   input  logic [15:0]              LinkPC,
   input  logic [3:0]               LinkReg,
   output logic                     Ready,
   input  logic                     WbReq,
   input  logic [3:0]               WbReg,
   input  logic [15:0]              WbData,
   output logic                     RegWrite,
   output logic [3:0]               WriteReg,
   output logic [15:0]              WriteData,
   input  logic [3:0]               LookupReg,
   output logic                     LookupHit,
   output logic [15:0]              LookupData,
   output logic [$clog2(DEPTH):0]   Pending,
   output logic                     Overflow
);

   localparam int            AW   = $clog2(DEPTH);
   localparam int            CW   = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic             overflow_q, overflow_d;
   logic             reg_write_q, reg_write_d;
   logic [3:0]       write_reg_q, write_reg_d;
   logic [15:0]      write_data_q, write_data_d;
   logic [3:0]       ent_reg_q  [DEPTH];
   logic [15:0]      ent_data_q [DEPTH];
   logic [15:0]      link_data_d;
   logic             do_enq;
   logic             do_pop;
   logic [AW-1:0]    fwd_idx;

   assign Ready       = (count_q < FULL);
   assign Pending     = count_q;
   assign Overflow    = overflow_q;
   assign RegWrite    = reg_write_q;
   assign WriteReg    = write_reg_q;
   assign WriteData   = write_data_q;
   assign link_data_d = LinkPC + INC;

   // r0 links are accepted (no overflow) but never occupy a slot
   assign do_enq = LinkReq && Ready && (LinkReg != 4'd0);
   assign do_pop = !WbReq && (count_q != '0);

   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      vld_d        = vld_q;
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      overflow_d   = overflow_q | (LinkReq & ~Ready);

      if (WbReq) begin
         reg_write_d  = 1'b1;
         write_reg_d  = WbReg;
         write_data_d = WbData;
         // the writeback is younger, so queued links to the same register are stale
         for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (ent_reg_q[i] == WbReg)) begin
               vld_d[i] = 1'b0;
            end
         end
      end else if (do_pop) begin
         reg_write_d = vld_q[head_q];
         if (vld_q[head_q]) begin
            write_reg_d  = ent_reg_q[head_q];
            write_data_d = ent_data_q[head_q];
         end
         vld_d[head_q] = 1'b0;
         head_d        = head_q + 1'b1;
      end

      if (do_enq) begin
         vld_d[tail_q] = 1'b1;
         tail_d        = tail_q + 1'b1;
      end

      count_d = count_q + CW'(do_enq) - CW'(do_pop);
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         vld_q        <= '0;
         overflow_q   <= 1'b0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         vld_q        <= vld_d;
         overflow_q   <= overflow_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   // entry payload is qualified by vld_q, so it needs no reset
   always_ff @(posedge CLK) begin
      if (do_enq) begin
         ent_reg_q[tail_q]  <= LinkReg;
         ent_data_q[tail_q] <= link_data_d;
      end
   end

   // scan oldest to newest so the newest matching entry wins over older ones and the output stage
   always_comb begin
      LookupHit  = 1'b0;
      LookupData = '0;
      fwd_idx    = head_q;
      if (reg_write_q && (write_reg_q == LookupReg)) begin
         LookupHit  = 1'b1;
         LookupData = write_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head_q + AW'(i);
         if (vld_q[fwd_idx] && (ent_reg_q[fwd_idx] == LookupReg)) begin
            LookupHit  = 1'b1;
            LookupData = ent_data_q[fwd_idx];
         end
      end
      if (LookupReg == 4'd0) begin
         LookupHit  = 1'b0;
         LookupData = '0;
      end
   end

endmodule

// File: tb/tb_link_writer.sv
// Directed bench for link_writer: expected RegFile writes are queued as stimulus is
// applied and compared whenever the DUT asserts RegWrite.
module tb_link_writer;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        LinkReq;
   logic [15:0] LinkPC;
   logic [3:0]  LinkReg;
   logic        Ready;
   logic        WbReq;
   logic [3:0]  WbReg;
   logic [15:0] WbData;
   logic        RegWrite;
   logic [3:0]  WriteReg;
   logic [15:0] WriteData;
   logic [3:0]  LookupReg;
   logic        LookupHit;
   logic [15:0] LookupData;
   logic [1:0]  Pending;
   logic        Overflow;

   typedef struct packed {
      logic [3:0]  r;
      logic [15:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   link_writer #(.DEPTH(2), .INC(16'd1)) dut (
      .CLK(CLK), .Reset(Reset),
      .LinkReq(LinkReq), .LinkPC(LinkPC), .LinkReg(LinkReg), .Ready(Ready),
      .WbReq(WbReq), .WbReg(WbReg), .WbData(WbData),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .LookupReg(LookupReg), .LookupHit(LookupHit), .LookupData(LookupData),
      .Pending(Pending), .Overflow(Overflow)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_check();
      wr_t e;
      if (RegWrite === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_extra observed=%0h/%0h expected=none", WriteReg, WriteData);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_write", {12'd0, WriteReg, WriteData}, {12'd0, e.r, e.d});
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      sb_check();
   endtask

   task automatic lookup(input string tag, input logic [3:0] r, input logic hit, input logic [15:0] d);
      LookupReg = r;
      #1;
      chk({tag, "_hit"}, LookupHit, hit);
      chk({tag, "_data"}, LookupData, d);
   endtask

   initial begin
      Reset = 1'b1; LinkReq = 1'b0; LinkPC = '0; LinkReg = '0;
      WbReq = 1'b0; WbReg = '0; WbData = '0; LookupReg = '0;
      #1;
      chk("rst_regwrite", RegWrite, 0);
      chk("rst_writereg", WriteReg, 0);
      chk("rst_writedata", WriteData, 0);
      chk("rst_pending", Pending, 0);
      chk("rst_overflow", Overflow, 0);
      tick(); tick();
      Reset = 1'b0;
      chk("rst_ready", Ready, 1);

      // single link on an idle port
      LinkReq = 1'b1; LinkPC = 16'h0010; LinkReg = 4'd1;
      exp_q.push_back('{4'd1, 16'h0011});
      tick();
      LinkReq = 1'b0;
      chk("t1_pending1", Pending, 1);
      chk("t1_nowrite_yet", RegWrite, 0);
      lookup("t1_fifo_fwd", 4'd1, 1'b1, 16'h0011);
      tick();
      chk("t1_regwrite", RegWrite, 1);
      chk("t1_pending0", Pending, 0);
      lookup("t1_out_fwd", 4'd1, 1'b1, 16'h0011);
      tick();
      chk("t1_idle", RegWrite, 0);

      // writeback takes priority over a queued link
      LinkReq = 1'b1; LinkPC = 16'h0020; LinkReg = 4'd2;
      tick();
      LinkReq = 1'b0;
      WbReq = 1'b1; WbReg = 4'd3; WbData = 16'h00AA;
      exp_q.push_back('{4'd3, 16'h00AA});
      tick();
      chk("t2_wb1", RegWrite, 1);
      chk("t2_pending_held", Pending, 1);
      exp_q.push_back('{4'd3, 16'h00AA});
      tick();
      chk("t2_wb2", RegWrite, 1);
      WbReq = 1'b0;
      exp_q.push_back('{4'd2, 16'h0021});
      tick();
      chk("t2_link_write", RegWrite, 1);
      chk("t2_pending0", Pending, 0);
      tick();
      chk("t2_idle", RegWrite, 0);

      // writeback to the same register invalidates the queued link
      LinkReq = 1'b1; LinkPC = 16'h0040; LinkReg = 4'd4;
      tick();
      LinkReq = 1'b0;
      chk("t3_pending_a", Pending, 1);
      WbReq = 1'b1; WbReg = 4'd4; WbData = 16'h1234;
      exp_q.push_back('{4'd4, 16'h1234});
      tick();
      WbReq = 1'b0;
      chk("t3_pending_b", Pending, 1);
      lookup("t3_stale_fwd", 4'd4, 1'b1, 16'h1234);
      tick();
      chk("t3_stale_pop_nowrite", RegWrite, 0);
      chk("t3_pending_c", Pending, 0);
      chk("t3_hold_reg", WriteReg, 4);
      chk("t3_hold_data", WriteData, 16'h1234);
      lookup("t3_nohit", 4'd4, 1'b0, 16'h0000);

      // fill under writeback pressure, drop the third link
      WbReq = 1'b1; WbReg = 4'd7; WbData = 16'h0777;
      LinkReq = 1'b1; LinkPC = 16'h0100; LinkReg = 4'd8;
      exp_q.push_back('{4'd7, 16'h0777});
      tick();
      chk("t4_ready_1", Ready, 1);
      LinkPC = 16'h0200; LinkReg = 4'd8;
      exp_q.push_back('{4'd7, 16'h0777});
      tick();
      chk("t4_full_ready", Ready, 0);
      chk("t4_full_pending", Pending, 2);
      chk("t4_no_ovf_yet", Overflow, 0);
      LinkPC = 16'h0300; LinkReg = 4'd10;
      exp_q.push_back('{4'd7, 16'h0777});
      tick();
      LinkReq = 1'b0;
      chk("t4_overflow", Overflow, 1);
      chk("t4_pending_still2", Pending, 2);
      lookup("t4_newest_wins", 4'd8, 1'b1, 16'h0201);
      lookup("t4_dropped_nohit", 4'd10, 1'b0, 16'h0000);
      lookup("t4_out_stage", 4'd7, 1'b1, 16'h0777);
      WbReq = 1'b0;
      exp_q.push_back('{4'd8, 16'h0101});
      exp_q.push_back('{4'd8, 16'h0201});
      tick();
      chk("t4_drain_pending", Pending, 1);
      lookup("t4_fifo_over_out", 4'd8, 1'b1, 16'h0201);
      tick();
      chk("t4_drained", Pending, 0);
      chk("t4_ovf_sticky", Overflow, 1);

      // 16-bit wrap of the return address and the r0 link
      LinkReq = 1'b1; LinkPC = 16'hFFFF; LinkReg = 4'd5;
      exp_q.push_back('{4'd5, 16'h0000});
      tick();
      chk("t5_pending1", Pending, 1);
      LinkPC = 16'h0050; LinkReg = 4'd0;
      tick();
      LinkReq = 1'b0;
      chk("t5_wrap_write", RegWrite, 1);
      chk("t5_r0_not_stored", Pending, 0);
      lookup("t5_r0_nohit", 4'd0, 1'b0, 16'h0000);
      tick();
      chk("t5_r0_nowrite", RegWrite, 0);

      // asynchronous reset with two links queued
      WbReq = 1'b1; WbReg = 4'd1; WbData = 16'h0055;
      LinkReq = 1'b1; LinkPC = 16'h00B0; LinkReg = 4'd11;
      exp_q.push_back('{4'd1, 16'h0055});
      tick();
      LinkPC = 16'h00C0; LinkReg = 4'd12;
      exp_q.push_back('{4'd1, 16'h0055});
      tick();
      LinkReq = 1'b0; WbReq = 1'b0;
      chk("t6_pending2", Pending, 2);
      Reset = 1'b1;
      #1;
      chk("t6_rst_regwrite", RegWrite, 0);
      chk("t6_rst_pending", Pending, 0);
      chk("t6_rst_overflow", Overflow, 0);
      chk("t6_rst_data", WriteData, 0);
      #1;
      Reset = 1'b0;
      tick();
      chk("t6_no_write_a", RegWrite, 0);
      tick();
      chk("t6_no_write_b", RegWrite, 0);
      chk("t6_pending_after", Pending, 0);

      chk("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
